// File: rtl/sio_pkg.sv
// sio_pkg -- shared widths and reset divisor for the SIO baud-rate generator.
// Rev 1.0
`default_nettype none

package sio_pkg;

  localparam int SIO_DIV_W   = 16;
  localparam int SIO_FRAC_W  = 4;
  localparam int SIO_OVS     = 16;
  localparam int SIO_OVS_W   = $clog2(SIO_OVS);

  localparam int SYS_CLK_HZ  = 50_000_000;
  localparam int SIO_BAUD    = 9600;
  localparam int SIO_OS_HZ   = SIO_BAUD * SIO_OVS;

  // 50 MHz / (9600 * 16) = 325 + 8/16 (truncated fraction)
  localparam int SIO_DEFAULT_DIV  = SYS_CLK_HZ / SIO_OS_HZ;
  localparam int SIO_DEFAULT_FRAC = ((SYS_CLK_HZ % SIO_OS_HZ) << SIO_FRAC_W) / SIO_OS_HZ;

endpackage

`default_nettype wire

// File: rtl/sio_frac_period.sv
// sio_frac_period -- fractional-N period counter producing a boundary strobe.
// Rev 1.0
`default_nettype none

module sio_frac_period
  import sio_pkg::*;
#(
  parameter int CNT_W   = SIO_DIV_W,
  parameter int FRAC_W  = SIO_FRAC_W,
  parameter int RST_LEN = SIO_DEFAULT_DIV
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              run_i,
  input  logic              clr_i,
  input  logic [CNT_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              bnd_o
);

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  logic [CNT_W:0]  cnt_q, cnt_d;
  logic [CNT_W:0]  len_q, len_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0] sum;

  assign bnd_o = run_i && (cnt_q == (len_q - ONE));
  assign sum   = {1'b0, acc_q} + {1'b0, frac_i};

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    len_d = len_q;
    if (clr_i) begin
      cnt_d = '0;
      acc_d = '0;
      len_d = {1'b0, div_i};
    end else if (bnd_o) begin
      // len is one bit wider than D so D+carry cannot wrap
      cnt_d = '0;
      acc_d = sum[FRAC_W-1:0];
      len_d = {1'b0, div_i} + {{CNT_W{1'b0}}, sum[FRAC_W]};
    end else if (run_i) begin
      cnt_d = cnt_q + ONE;
    end else begin
      len_d = {1'b0, div_i};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      len_q <= (CNT_W+1)'(RST_LEN);
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      len_q <= len_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sio_baud_gen.sv
// sio_baud_gen -- programmable fractional baud generator: oversample tick, bit tick, sio_clk.
// Rev 1.0
`default_nettype none

module sio_baud_gen
  import sio_pkg::*;
#(
  parameter int CNT_W        = SIO_DIV_W,
  parameter int FRAC_W       = SIO_FRAC_W,
  parameter int OVS          = SIO_OVS,
  parameter int DEFAULT_DIV  = SIO_DEFAULT_DIV,
  parameter int DEFAULT_FRAC = SIO_DEFAULT_FRAC
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en_i,
  input  logic              div_wr_i,
  input  logic [CNT_W-1:0]  div_in_i,
  input  logic [FRAC_W-1:0] frac_in_i,
  output logic              tick_os_o,
  output logic              tick_bit_o,
  output logic              sio_clk_o,
  output logic [CNT_W-1:0]  div_active_o,
  output logic              upd_pending_o
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0]  OS_LAST  = OVS_W'(OVS - 1);
  localparam logic [CNT_W-1:0]  RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);

  logic [CNT_W-1:0]  act_div_q, act_div_d, shd_div_q, shd_div_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic [OVS_W-1:0]  os_cnt_q, os_cnt_d;
  logic              sio_q, sio_d;
  logic              tick_os_q, tick_bit_q;

  logic              run, bnd, apply;
  logic [CNT_W-1:0]  div_eff;
  logic [FRAC_W-1:0] frac_eff;

  assign run = en_i && (act_div_q != '0);
  // Outside normal counting (disabled or D=0) a pending shadow need not wait for a boundary
  assign apply    = pend_q && (bnd || !run);
  assign div_eff  = apply ? shd_div_q  : act_div_q;
  assign frac_eff = apply ? shd_frac_q : act_frac_q;

  sio_frac_period #(
    .CNT_W   (CNT_W),
    .FRAC_W  (FRAC_W),
    .RST_LEN (DEFAULT_DIV)
  ) u_period (
    .clk    (clk),
    .n_rst  (n_rst),
    .run_i  (run),
    .clr_i  (!en_i),
    .div_i  (div_eff),
    .frac_i (frac_eff),
    .bnd_o  (bnd)
  );

  always_comb begin
    act_div_d  = div_eff;
    act_frac_d = frac_eff;
    shd_div_d  = shd_div_q;
    shd_frac_d = shd_frac_q;
    pend_d     = pend_q;
    os_cnt_d   = os_cnt_q;
    sio_d      = sio_q;

    if (div_wr_i) begin
      shd_div_d  = div_in_i;
      shd_frac_d = frac_in_i;
      pend_d     = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end

    if (!en_i) begin
      os_cnt_d = '0;
      sio_d    = 1'b0;
    end else if (bnd) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OVS_W'(1);
      sio_d    = ~sio_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_div_q  <= RST_DIV;
      act_frac_q <= RST_FRAC;
      shd_div_q  <= RST_DIV;
      shd_frac_q <= RST_FRAC;
      pend_q     <= 1'b0;
      os_cnt_q   <= '0;
      sio_q      <= 1'b0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
    end else begin
      act_div_q  <= act_div_d;
      act_frac_q <= act_frac_d;
      shd_div_q  <= shd_div_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      os_cnt_q   <= os_cnt_d;
      sio_q      <= sio_d;
      tick_os_q  <= bnd;
      tick_bit_q <= bnd && (os_cnt_q == OS_LAST);
    end
  end

  assign tick_os_o     = tick_os_q;
  assign tick_bit_o    = tick_bit_q;
  assign sio_clk_o     = sio_q;
  assign div_active_o  = act_div_q;
  assign upd_pending_o = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_sio_baud_gen.sv
// tb_sio_baud_gen -- self-checking bench for sio_baud_gen.
// Rev 1.0
`default_nettype none

module tb_sio_baud_gen;

  localparam int CNT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              en = 1'b0;
  logic              wr = 1'b0;
  logic [CNT_W-1:0]  din = '0;
  logic [FRAC_W-1:0] fin = '0;
  logic              tick_os, tick_bit, sio_clk, upd_pending;
  logic [CNT_W-1:0]  div_active;

  always #10 clk = ~clk;

  sio_baud_gen #(
    .CNT_W        (CNT_W),
    .FRAC_W       (FRAC_W),
    .OVS          (OVS),
    .DEFAULT_DIV  (325),
    .DEFAULT_FRAC (8)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .en_i          (en),
    .div_wr_i      (wr),
    .div_in_i      (din),
    .frac_in_i     (fin),
    .tick_os_o     (tick_os),
    .tick_bit_o    (tick_bit),
    .sio_clk_o     (sio_clk),
    .div_active_o  (div_active),
    .upd_pending_o (upd_pending)
  );

  int errs = 0;
  int checks = 0;

  // Reference model: time into current period, period length, fraction sum, boundary count
  int m_D, m_F, m_sD, m_sF, m_pend, m_el, m_per, m_fsum, m_nb;
  int m_tick, m_bit;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_D = 325; m_F = 8; m_sD = 325; m_sF = 8; m_pend = 0;
    m_el = 0; m_per = 325; m_fsum = 0; m_nb = 0; m_tick = 0; m_bit = 0;
  endtask

  task automatic model_edge();
    int bnd, apply, nD, nF;
    if (!n_rst) begin
      model_reset();
      return;
    end
    bnd   = (en && m_D != 0 && m_el == m_per - 1) ? 1 : 0;
    apply = (m_pend != 0 && (bnd != 0 || !en || m_D == 0)) ? 1 : 0;
    nD = apply ? m_sD : m_D;
    nF = apply ? m_sF : m_F;
    if (!en) begin
      m_el = 0; m_fsum = 0; m_nb = 0; m_per = nD;
    end else if (bnd) begin
      m_el = 0;
      m_fsum = m_fsum + nF;
      m_per = nD + (m_fsum >= (1 << FRAC_W) ? 1 : 0);
      m_fsum = m_fsum % (1 << FRAC_W);
      m_nb++;
    end else if (m_D != 0) begin
      m_el++;
    end else begin
      m_per = nD;
    end
    m_tick = bnd;
    m_bit  = (bnd != 0 && (m_nb % OVS) == 0) ? 1 : 0;
    if (wr) begin
      m_sD = int'(din); m_sF = int'(fin); m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    m_D = nD; m_F = nF;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("tick_os",     int'(tick_os),     m_tick);
    check("tick_bit",    int'(tick_bit),    m_bit);
    check("sio_clk",     int'(sio_clk),     m_nb % 2);
    check("div_active",  int'(div_active),  m_D);
    check("upd_pending", int'(upd_pending), m_pend);
  endtask

  task automatic write_div(input int d, input int f);
    din = CNT_W'(d); fin = FRAC_W'(f); wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  // Clocks until the next tick_os; -1 on timeout
  task automatic wait_tick(input string name, input int maxc, input int exp);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < maxc) begin
      step();
      n++;
      got = tick_os;
    end
    check(name, got ? n : -1, exp);
  endtask

  typedef struct {
    int d; int f; int n; int ticks; int bits; int first; int sio;
  } vec_t;

  vec_t tbl[6];
  int   tt[$];

  initial begin
    int first_bit, nt, nbits, first;

    tbl[0] = '{4, 0,  64, 16, 1, 4, 0};
    tbl[1] = '{4, 8, 144, 32, 2, 4, 0};
    tbl[2] = '{1, 0,  10, 10, 0, 1, 0};
    tbl[3] = '{3, 0,  48, 16, 1, 3, 0};
    tbl[4] = '{2, 15, 20,  7, 0, 2, 1};
    tbl[5] = '{0, 5,  20,  0, 0, 0, 0};

    model_reset();
    repeat (2) @(negedge clk);
    check("rst_tick_os", int'(tick_os), 0);
    check("rst_tick_bit", int'(tick_bit), 0);
    check("rst_sio_clk", int'(sio_clk), 0);
    check("rst_div_active", int'(div_active), 325);
    check("rst_upd_pending", int'(upd_pending), 0);
    n_rst = 1'b1;

    // Default divisor 325 + 8/16
    en = 1'b1;
    first_bit = -1;
    for (int c = 1; c <= 5220; c++) begin
      step();
      if (tick_os) tt.push_back(c);
      if (tick_bit && first_bit < 0) first_bit = c;
    end
    check("def_first", tt[0], 325);
    check("def_p2", tt[1] - tt[0], 325);
    check("def_p3", tt[2] - tt[1], 326);
    check("def_p4", tt[3] - tt[2], 325);
    check("def_nticks", tt.size(), 16);
    check("def_bit", first_bit, 5207);

    for (int i = 0; i < 6; i++) begin
      en = 1'b0;
      step();
      write_div(tbl[i].d, tbl[i].f);
      step();
      check("tbl_div_active", int'(div_active), tbl[i].d);
      en = 1'b1;
      nt = 0; nbits = 0; first = 0;
      for (int c = 1; c <= tbl[i].n; c++) begin
        step();
        if (tick_os) begin
          nt++;
          if (first == 0) first = c;
        end
        if (tick_bit) nbits++;
      end
      check("tbl_ticks", nt, tbl[i].ticks);
      check("tbl_bits", nbits, tbl[i].bits);
      check("tbl_first", first, tbl[i].first);
      check("tbl_sio", int'(sio_clk), tbl[i].sio);
    end

    // Stalled at D=0: write applies on the very next edge
    repeat (5) step();
    write_div(3, 0);
    check("stall_pend", int'(upd_pending), 1);
    check("stall_old_div", int'(div_active), 0);
    step();
    check("stall_new_div", int'(div_active), 3);
    wait_tick("stall_resume", 10, 3);
    wait_tick("stall_period", 10, 3);

    // Mid-period write at cnt=1 of a D=4 period
    en = 1'b0;
    write_div(4, 0);
    step();
    en = 1'b1;
    wait_tick("mid_first", 10, 4);
    step();
    write_div(6, 0);
    check("mid_pend", int'(upd_pending), 1);
    check("mid_old_div", int'(div_active), 4);
    wait_tick("mid_cur_period", 10, 2);
    check("mid_new_div", int'(div_active), 6);
    check("mid_pend_clr", int'(upd_pending), 0);
    wait_tick("mid_next_period", 10, 6);

    // Write coincident with a boundary, then last-write-wins
    repeat (5) step();
    write_div(5, 0);
    check("coinc_tick", int'(tick_os), 1);
    check("coinc_div", int'(div_active), 6);
    check("coinc_pend", int'(upd_pending), 1);
    write_div(7, 0);
    wait_tick("coinc_old_period", 10, 5);
    check("coinc_applied", int'(div_active), 7);
    wait_tick("coinc_new_period", 12, 7);

    // Asynchronous reset mid-period drops the shadow
    step();
    write_div(9, 0);
    @(negedge clk);
    n_rst = 1'b0;
    en = 1'b0;
    #1;
    check("arst_tick_os", int'(tick_os), 0);
    check("arst_sio_clk", int'(sio_clk), 0);
    check("arst_div_active", int'(div_active), 325);
    check("arst_pend", int'(upd_pending), 0);
    model_reset();
    step();
    n_rst = 1'b1;
    step();

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      en  = ($urandom_range(0, 99) < 96);
      wr  = ($urandom_range(0, 99) < 3);
      din = CNT_W'($urandom_range(0, 7));
      fin = FRAC_W'($urandom);
      step();
    end
    wr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sio_baud_gen.md
Name: sio_baud_gen

Overview:
- Runtime-programmable baud-rate generator for the SIO path.
- Replaces the fixed square-wave divider with three outputs:
  - a fractional-N oversample tick;
  - a bit-rate tick;
  - a legacy square-wave sio_clk.
- Divisor updates are glitch-free and take effect on period boundaries.
- Sits between the 50 MHz system clock and the UART TX/RX engines.

Parameters:
- CNT_W, 16, width of the integer divisor and period counter.
- FRAC_W, 4, width of the fractional divisor and phase accumulator.
- OVS, 16, oversample ticks per bit; must be ≥2.
- DEFAULT_DIV, 325, integer divisor after reset (50M/(9600·16) ≈ 325.52).
- DEFAULT_FRAC, 8, fractional divisor after reset (8/16 = 0.5).

Ports:
- clk  in  1  system clock, 50 MHz.
- n_rst  in  1  reset, asynchronous, active-low.
- en  in  1  generator run enable.
- div_wr  in  1  one-cycle write strobe for div_in/frac_in.
- div_in  in  CNT_W  new integer divisor D.
- frac_in  in  FRAC_W  new fractional divisor F.
- tick_os  out  1  one-cycle oversample strobe.
- tick_bit  out  1  one-cycle bit strobe, coincident with every OVS-th tick_os.
- sio_clk  out  1  toggles on every tick_os.
- div_active  out  CNT_W  integer divisor currently in use.
- upd_pending  out  1  shadow write not yet applied.

Behaviour:
- Reset (async): cnt=0, acc=0, os_cnt=0, len=DEFAULT_DIV, active D/F=DEFAULT_DIV/DEFAULT_FRAC, shadow=defaults; all 1-bit outputs 0.
- Counting (en=1, D≠0):
  - cnt increments each clk.
  - When cnt==len-1: cnt←0 and tick_os=1 (registered) in the next cycle.
  - First tick_os occurs D clocks after the first edge that samples en=1.
- Fractional accumulator, at each boundary (the edge where cnt wraps):
  - {carry, acc} ← acc + F.
  - The next period length len = D+1 if carry, else D.
  - The first period after enable is D.
  - Average period = D + F/2^FRAC_W.
- Bit tick:
  - os_cnt counts boundaries 0..OVS-1 and wraps.
  - tick_bit asserts together with tick_os when os_cnt was OVS-1.
- sio_clk: toggles at each boundary and is visible in the same cycle as tick_os.
- Divisor write:
  - div_wr captures div_in/frac_in into the shadow registers; upd_pending←1.
  - A later write before application overwrites the shadow (last wins).
- Divisor application:
  - Shadow→active at the next boundary, only if pending was set before that edge.
  - A write coincident with a boundary applies at the following boundary.
  - On apply: upd_pending←0 and len←new D (acc carry rule applies with new F).
- en=0:
  - Synchronously clears cnt, acc, os_cnt and sio_clk; no ticks.
  - A pending shadow is applied immediately (next edge).
  - Re-enabling restarts with a first period of D.
- D=0: generator stalled.
  - cnt held at 0, no ticks, sio_clk held.
  - A pending shadow is applied on the next edge regardless of boundary.
- D=1, F=0: tick_os held high continuously; sio_clk toggles every clk. This is legal.
- Width rules:
  - len is CNT_W+1 bits, so D+1 never overflows.
  - All compares are unsigned.
- Reset mid-period: all state returns to reset values immediately; the shadow is lost.

Decomposition:
- Package sio_pkg:
  - SIO_DIV_W and SIO_FRAC_W defaults;
  - OVS_W = $clog2(OVS);
  - a default-divisor constant for 9600 baud at 50 MHz.
- Sub-module sio_frac_period:
  - integer counter plus fractional accumulator;
  - outputs the boundary strobe and accepts load of D/F.
- Top level: shadow/pending logic, os_cnt, sio_clk, output registers.

Test Plan:
- Reset then en=1 with defaults → first tick_os at 325 clk; next periods 325, 326, 325, 326…; tick_bit every 16th tick_os.
- div_wr D=4, F=0 while en=0, then en=1 → tick_os at clk 4, 8, 12…; sio_clk period 8 clk; tick_bit every 64 clk.
- D=4, F=8, FRAC_W=4 → periods 4, 4, 5, 4, 5…; mean 4.5 over 32 ticks = 144 clk ±4.
- Mid-period write D=6 at cnt=1 of a D=4 period → current period stays 4; upd_pending 1 until boundary; next period 6; div_active changes at the boundary.
- Write coincident with a boundary edge → not applied at that boundary; applied at the next one. Two writes D=5 then D=7 before a boundary → only 7 is applied.
- Load D=0 → ticks stop and sio_clk is frozen. Write D=3 → applied next clk; ticks resume every 3 clk. Assert n_rst mid-period → outputs 0 and div_active=325 at once.
